// File: rtl/stopwatch100hz_pkg.sv
// Shared floppy peripheral constants for the 100 Hz stopwatch.
// Register addresses, status bit positions and prescaler helper.
package stopwatch100hz_pkg;

    localparam logic [1:0] REG_CNTLO  = 2'd0;
    localparam logic [1:0] REG_SNAPHI = 2'd1;
    localparam logic [1:0] REG_STATUS = 2'd2;

    localparam int ST_OVF  = 0;
    localparam int ST_RUN  = 1;
    localparam int ST_TICK = 7;

    localparam int PRE_W = 18;

    // Reload value giving one tick every f/100 clocks.
    function automatic logic [PRE_W-1:0] pre_of(int f);
        return PRE_W'(f / 100 - 1);
    endfunction

endpackage

// File: rtl/stopwatch100hz_if.sv
// CPU I/O bus for the stopwatch: addr/di/wren/rden in, registered q out.
// master = CPU side, slave = peripheral side.
interface stopwatch100hz_if;

    logic [1:0] addr;
    logic [7:0] di;
    logic       wren;
    logic       rden;
    logic [7:0] q;

    modport master (output addr, output di, output wren, output rden,
                    input q);
    modport slave  (input addr, input di, input wren, input rden,
                    output q);

endinterface

// File: rtl/stopwatch100hz_tick_prescaler.sv
// Reloadable 18-bit down-counter producing a one-cycle tick at zero.
// Ports: clk, reset_n (sync, active-low), en, reload, tick.
module tick_prescaler
    import stopwatch100hz_pkg::*;
#(
    parameter logic [PRE_W-1:0] PRE = 18'd239999
) (
    input  logic clk,
    input  logic reset_n,
    input  logic en,
    input  logic reload,
    output logic tick
);

    logic [PRE_W-1:0] cnt;

    // A reload in the same cycle swallows the tick.
    assign tick = en && !reload && (cnt == '0);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            cnt <= PRE;
        end else if (reload) begin
            cnt <= PRE;
        end else if (en) begin
            cnt <= (cnt == '0) ? PRE : cnt - 1'b1;
        end
    end

endmodule

// File: rtl/stopwatch100hz.sv
// Elapsed-time counter, 10 ms resolution, for the floppy CPU.
// Ports: clk, reset_n (sync, active-low), bus (addr/di/wren/rden/q).
module stopwatch100hz
    import stopwatch100hz_pkg::*;
#(
    parameter int MCLKFREQ = 24000000
) (
    input  logic                    clk,
    input  logic                    reset_n,
    stopwatch100hz_if.slave         bus
);

    localparam logic [PRE_W-1:0] PRE = pre_of(MCLKFREQ);

    logic [15:0] count;
    logic [7:0]  snap_hi;
    logic        run;
    logic        ovf;
    logic        tickf;
    logic        tick;
    logic [7:0]  status;

    logic wr_lo, wr_st;
    logic rd_lo, rd_hi, rd_st;
    logic wrap;
    logic unused_di;

    assign wr_lo = bus.wren && (bus.addr == REG_CNTLO);
    assign wr_st = bus.wren && (bus.addr == REG_STATUS);
    assign rd_lo = bus.rden && (bus.addr == REG_CNTLO);
    assign rd_hi = bus.rden && (bus.addr == REG_SNAPHI);
    assign rd_st = bus.rden && (bus.addr == REG_STATUS);
    assign wrap  = tick && (count == 16'hFFFF);

    assign unused_di = ^bus.di[7:2];

    tick_prescaler #(.PRE(PRE)) u_pre (
        .clk     (clk),
        .reset_n (reset_n),
        .en      (run),
        .reload  (wr_lo),
        .tick    (tick)
    );

    always_comb begin
        status          = '0;
        status[ST_TICK] = tickf;
        status[ST_RUN]  = run;
        status[ST_OVF]  = ovf;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            count <= '0;
            ovf   <= 1'b0;
            tickf <= 1'b0;
            run   <= 1'b0;
        end else begin
            if (wr_lo) begin
                count <= '0;
                ovf   <= 1'b0;
                tickf <= 1'b0;
            end else begin
                if (tick)
                    count <= count + 16'd1;
                // Set beats clear for both sticky flags.
                if (wrap)
                    ovf <= 1'b1;
                else if (wr_st && bus.di[ST_OVF])
                    ovf <= 1'b0;
                if (tick)
                    tickf <= 1'b1;
                else if (rd_st)
                    tickf <= 1'b0;
            end
            if (wr_st)
                run <= bus.di[ST_RUN];
        end
    end

    // Reading the low byte freezes the high byte for a later read.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            snap_hi <= '0;
            bus.q   <= '0;
        end else begin
            if (rd_lo)
                snap_hi <= count[15:8];
            unique case (1'b1)
                rd_lo:   bus.q <= count[7:0];
                rd_hi:   bus.q <= snap_hi;
                rd_st:   bus.q <= status;
                default: if (bus.rden) bus.q <= 8'h00;
            endcase
        end
    end

endmodule

// File: tb/tb_stopwatch100hz.sv
// Randomized + directed bench for stopwatch100hz against an elapsed-time model.
// Two instances: 10-clock tick period and 1-clock tick period (for wrap).
module tb_stopwatch100hz;

    logic clk = 1'b0;
    logic rst_a, rst_b;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    stopwatch100hz_if ifa ();
    stopwatch100hz_if ifb ();

    stopwatch100hz #(.MCLKFREQ(1000)) dut_a (
        .clk     (clk),
        .reset_n (rst_a),
        .bus     (ifa)
    );

    stopwatch100hz #(.MCLKFREQ(100)) dut_b (
        .clk     (clk),
        .reset_n (rst_b),
        .bus     (ifb)
    );

    typedef struct {
        int        period;
        int        phase;
        bit        run;
        bit [15:0] count;
        bit        ovf;
        bit        tickf;
        bit [7:0]  snap;
        bit [7:0]  q;
    } mdl_t;

    mdl_t ma, mb;

    task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    function automatic mdl_t mreset(int period);
        mdl_t m;
        m.period = period;
        m.phase  = 0;
        m.run    = 0;
        m.count  = 0;
        m.ovf    = 0;
        m.tickf  = 0;
        m.snap   = 0;
        m.q      = 0;
        return m;
    endfunction

    // phase = running clocks elapsed inside the current tick period.
    function automatic mdl_t step(mdl_t m, bit [1:0] a, bit [7:0] d,
                                  bit w, bit r);
        mdl_t n = m;
        bit tk   = m.run && (m.phase == m.period - 1);
        bit wrp  = tk && (m.count == 16'hFFFF);
        bit [7:0] st = {m.tickf, 5'b0, m.run, m.ovf};
        if (r) begin
            case (a)
                2'd0: begin n.q = m.count[7:0]; n.snap = m.count[15:8]; end
                2'd1: n.q = m.snap;
                2'd2: n.q = st;
                default: n.q = 8'h00;
            endcase
        end
        if (m.run) n.phase = (m.phase + 1) % m.period;
        if (tk) begin
            n.count = m.count + 16'd1;
            n.tickf = 1;
            if (wrp) n.ovf = 1;
        end
        if (r && a == 2'd2 && !tk) n.tickf = 0;
        if (w && a == 2'd2) begin
            n.run = d[1];
            if (d[0] && !wrp) n.ovf = 0;
        end
        if (w && a == 2'd0) begin
            n.count = 0;
            n.ovf   = 0;
            n.tickf = 0;
            n.phase = 0;
        end
        return n;
    endfunction

    task automatic cyc_a(string tag, bit [1:0] a, bit [7:0] d, bit w, bit r);
        ifa.addr = a; ifa.di = d; ifa.wren = w; ifa.rden = r;
        @(posedge clk);
        ma = step(ma, a, d, w, r);
        #1;
        check(tag, ifa.q, ma.q);
    endtask

    task automatic cyc_b(string tag, bit [1:0] a, bit [7:0] d, bit w, bit r);
        ifb.addr = a; ifb.di = d; ifb.wren = w; ifb.rden = r;
        @(posedge clk);
        mb = step(mb, a, d, w, r);
        #1;
        check(tag, ifb.q, mb.q);
    endtask

    task automatic reset_a(string tag);
        rst_a = 0;
        ifa.addr = 0; ifa.di = 0; ifa.wren = 0; ifa.rden = 0;
        @(posedge clk);
        ma = mreset(10);
        #1;
        check(tag, ifa.q, ma.q);
        rst_a = 1;
    endtask

    task automatic proc_a();
        int n;
        reset_a("a_rst");
        cyc_a("a_st0", 2, 0, 0, 1);
        for (int i = 0; i < 100; i++) cyc_a("a_idle", 0, 0, 0, 0);
        cyc_a("a_cnt0", 0, 0, 0, 1);
        // start and watch the first ticks
        cyc_a("a_go", 2, 8'h02, 1, 0);
        for (int i = 0; i < 10; i++) cyc_a("a_run", 0, 0, 0, 0);
        cyc_a("a_st1", 2, 0, 0, 1);
        cyc_a("a_st2", 2, 0, 0, 1);
        for (int i = 0; i < 38; i++) cyc_a("a_run", 0, 0, 0, 0);
        cyc_a("a_cnt5", 0, 0, 0, 1);
        // clear on the exact tick cycle
        n = 0;
        while (!(ma.run && ma.phase == ma.period - 1) && n < 50) begin
            cyc_a("a_wt", 0, 0, 0, 0);
            n++;
        end
        if (n >= 50) check("a_tmo_tick", 1, 0);
        cyc_a("a_clr", 0, 8'h5A, 1, 0);
        cyc_a("a_clr_st", 2, 0, 0, 1);
        for (int i = 0; i < 8; i++) cyc_a("a_run", 0, 0, 0, 0);
        cyc_a("a_clr9", 0, 0, 0, 1);
        cyc_a("a_clr10", 0, 0, 0, 1);
        // stop with prescaler at 4, hold, restart
        n = 0;
        while (ma.phase != 4 && n < 50) begin
            cyc_a("a_wt", 0, 0, 0, 0);
            n++;
        end
        if (n >= 50) check("a_tmo_ph", 1, 0);
        cyc_a("a_stop", 2, 8'h00, 1, 0);
        cyc_a("a_hold", 0, 0, 0, 1);
        for (int i = 0; i < 50; i++) cyc_a("a_idle", 0, 0, 0, 0);
        cyc_a("a_hold2", 0, 0, 0, 1);
        cyc_a("a_rest", 2, 8'h02, 1, 0);
        for (int i = 0; i < 3; i++) cyc_a("a_run", 0, 0, 0, 0);
        cyc_a("a_rest4", 0, 0, 0, 1);
        cyc_a("a_rest5", 0, 0, 0, 1);
        // read and write together
        cyc_a("a_rw", 2, 8'h03, 1, 1);
        cyc_a("a_rw2", 2, 0, 0, 1);
        // random traffic
        for (int i = 0; i < 600; i++) begin
            bit [1:0] a = 2'($urandom_range(0, 3));
            bit [7:0] d = 8'($urandom);
            bit w = ($urandom_range(0, 11) == 0);
            bit r = ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 3) == 0) d[1] = 1;
            cyc_a("a_rnd", a, d, w, r);
        end
        // reset in the middle of a run
        cyc_a("a_go2", 2, 8'h02, 1, 0);
        for (int i = 0; i < 27; i++) cyc_a("a_run", 0, 0, 0, 0);
        cyc_a("a_pre", 0, 0, 0, 1);
        reset_a("a_mrst");
        cyc_a("a_r_st", 2, 0, 0, 1);
        cyc_a("a_r_lo", 0, 0, 0, 1);
        cyc_a("a_r_hi", 1, 0, 0, 1);
        cyc_a("a_r_3", 3, 0, 0, 1);
        for (int i = 0; i < 12; i++) cyc_a("a_idle", 0, 0, 0, 0);
        cyc_a("a_r_lo2", 0, 0, 0, 1);
    endtask

    task automatic proc_b();
        int n;
        rst_b = 0;
        ifb.addr = 0; ifb.di = 0; ifb.wren = 0; ifb.rden = 0;
        @(posedge clk);
        mb = mreset(1);
        #1;
        check("b_rst", ifb.q, mb.q);
        rst_b = 1;
        cyc_b("b_go", 2, 8'h02, 1, 0);
        // snapshot coherence around 0x12FF -> 0x1300
        n = 0;
        while (mb.count != 16'h12FF && n < 6000) begin
            cyc_b("b_run", 0, 0, 0, 0);
            n++;
        end
        if (n >= 6000) check("b_tmo_12ff", 1, 0);
        cyc_b("b_lo", 0, 0, 0, 1);
        cyc_b("b_hi", 1, 0, 0, 1);
        cyc_b("b_lo2", 0, 0, 0, 1);
        cyc_b("b_hi2", 1, 0, 0, 1);
        // run to wrap; ovf set beats the clear on the same cycle
        n = 0;
        while (mb.count != 16'hFFFF && n < 70000) begin
            cyc_b("b_run", 0, 0, 0, 0);
            n++;
        end
        if (n >= 70000) check("b_tmo_wrap", 1, 0);
        cyc_b("b_wrapw", 2, 8'h03, 1, 0);
        cyc_b("b_stop", 2, 8'h00, 1, 0);
        cyc_b("b_ovf", 2, 0, 0, 1);
        cyc_b("b_cnt", 0, 0, 0, 1);
        cyc_b("b_clr", 2, 8'h03, 1, 0);
        cyc_b("b_st", 2, 0, 0, 1);
        cyc_b("b_st2", 2, 0, 0, 1);
    endtask

    initial begin
        rst_a = 0;
        rst_b = 0;
        ifa.addr = 0; ifa.di = 0; ifa.wren = 0; ifa.rden = 0;
        ifb.addr = 0; ifb.di = 0; ifb.wren = 0; ifb.rden = 0;
        ma = mreset(10);
        mb = mreset(1);
        #2;
        fork
            proc_a();
            proc_b();
        join
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/stopwatch100hz.md
# stopwatch100hz

Free-running elapsed-time counter with 10 ms resolution, used as a peripheral for the floppy CPU. It is the measuring counterpart of the floppy delay timer. The CPU starts it, lets it count up in 100 Hz ticks, and reads back a consistent 16-bit elapsed value through a low-byte-latches-high-byte snapshot. It sits on the floppy CPU's I/O decode next to the other floppy peripherals.

## Interface
- MCLKFREQ, 24000000, master clock frequency in Hz; one tick every MCLKFREQ/100 clocks.
- clk  in  1  master clock; all logic on rising edge.
- reset_n  in  1  synchronous reset, active-low.
- addr  in  2  register select.
- di  in  8  write data.
- wren  in  1  write strobe; one write per asserted cycle.
- rden  in  1  read strobe; one read per asserted cycle. Side effects apply once per asserted cycle.
- q  out  8  registered read data.

## Operation
- Prescaler: 18-bit down-counter. Reload value PRE = MCLKFREQ/100 - 1; PRE must fit in 18 bits.
  - While run=1, it decrements each clock. At 0 it reloads PRE and asserts an internal tick for that cycle.
  - While run=0, it holds its value and no tick occurs.
- Counter: 16-bit count of ticks. It increments on tick. 0xFFFF plus a tick wraps to 0x0000 and sets the sticky ovf bit.
- Snapshot: 8-bit register snap_hi.
- Register map, reads:
  - addr 0: returns count[7:0] and loads snap_hi <= count[15:8] in the same cycle. This is the current count, before any same-cycle increment.
  - addr 1: returns snap_hi.
  - addr 2: returns status {tickf, 5'b0, run, ovf}. Reading clears tickf.
  - addr 3: returns 0x00.
- Register map, writes:
  - addr 0, any data: clears count, ovf and tickf, and reloads the prescaler with PRE. run is unchanged.
  - addr 2: run <= di[1]. Writing di[0]=1 clears ovf.
  - addr 1 and addr 3: writes are ignored.
- tickf is set on every tick.
- Precedence when events coincide in one cycle:
  - addr-0 write versus tick: the clear wins. count=0, tickf=0, and the prescaler is reloaded.
  - Status read versus tick: the set wins, so tickf stays 1.
  - Tick at 0xFFFF versus an addr-2 write with di[0]=1: the set wins, so ovf=1.
  - wren and rden together: both take effect. Read data reflects pre-write state.

## Timing
- Reset values when reset_n=0 at an edge: q=0x00, count=0, snap_hi=0, prescaler=PRE, run=0, ovf=0, tickf=0.
- Reset mid-count discards all state, with no partial effects.
- Read latency is 1 clock: q is valid on the edge after the rden cycle. q holds its last value when rden=0.
- Writes take effect at the edge ending the wren cycle.
- After an addr-2 write with run=1 at edge E, starting from prescaler=PRE, the first tick occurs PRE+1 clocks later. count=1 is visible after edge E+PRE+1.
- Tick period is exactly MCLKFREQ/100 clocks while run=1.
- Stopping and restarting resumes from the held prescaler value, so no time is lost or gained.

## Structure
- Constants for register addresses (REG_CNTLO=0, REG_SNAPHI=1, REG_STATUS=2) and status bit positions (ST_OVF=0, ST_RUN=1, ST_TICK=7) belong in the shared floppy peripheral package.
- One sub-module is natural: tick_prescaler, which holds the 18-bit reloadable prescaler and has ports clk, reset_n, en, reload, tick.
- The rest goes in the top module: counter, snapshot, status and read mux.

## Test plan
All scenarios use MCLKFREQ=1000, so PRE=9 and the tick period is 10 clocks.
- Reset, then read addr 2 → q=0x00. Hold run=0 for 100 clocks, then read addr 0 → 0x00.
- Write addr 2 = 0x02 at cycle 0 → count=1 after cycle 10 and count=5 after cycle 50. A status read at cycle 11 → 0x82; an immediate re-read → 0x02.
- Force count to 0x12FF via 0x12FF ticks, read addr 0 → 0xFF. Wait one tick, read addr 1 → 0x12, not 0x13. A new addr-0 read → 0x00; then addr 1 → 0x13.
- Run 0x10000 ticks → count=0 and status bit0=1. Write addr 2 = 0x03 → ovf=0 and run stays 1.
- Issue an addr-0 write on the exact tick cycle → count=0 and tickf=0; the next tick arrives 10 clocks later.
- Stop (addr 2 = 0x00) with prescaler at 4, wait 50 clocks, restart → the next tick arrives 5 clocks later. Assert reset_n=0 mid-run → all registers are at reset values on the next edge.
